// File: rtl/pipe_execute_if.sv
// Execute-stage bus: operands from the D->E register in, forwarding taps and
// E->M register contents out. The stage drives "slave", the upstream side "master".
interface pipe_execute_if;
  logic [1:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valC;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  logic [1:0]  m_stat;
  logic [1:0]  W_stat;
  logic        M_bubble;

  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;

  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;

  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    output m_stat, W_stat, M_bubble,
    input  e_valE, e_dstE, e_Cnd,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    input  m_stat, W_stat, M_bubble,
    output e_valE, e_dstE, e_Cnd,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/pipe_execute.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the
// E->M pipeline register with bubble insertion.
module pipe_execute (
  input  logic          clk,
  input  logic          rst_n,
  pipe_execute_if.slave ex
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [1:0] S_AOK  = 2'b00;
  localparam logic [3:0] R_NONE = 4'hF;

  localparam logic signed [63:0] STACK_STEP = 64'sd8;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  localparam cc_t    CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};
  localparam m_reg_t M_NOP    = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0,
                                  val_e: 64'd0, val_a: 64'd0,
                                  dst_e: R_NONE, dst_m: R_NONE};

  function automatic logic signed [63:0] alu_result(
    input logic [3:0]         fun,
    input logic signed [63:0] a,
    input logic signed [63:0] b
  );
    case (fun)
      A_ADD:   return b + a;
      A_SUB:   return b - a;
      A_AND:   return b & a;
      A_XOR:   return b ^ a;
      default: return 64'sd0;
    endcase
  endfunction

  // Overflow uses operand/result sign bits; logical ops never overflow.
  function automatic cc_t alu_flags(
    input logic [3:0]         fun,
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input logic signed [63:0] r
  );
    cc_t f;
    f.zf = (r == 64'sd0);
    f.sf = r[63];
    case (fun)
      A_ADD:   f.of = (a[63] == b[63]) && (r[63] != a[63]);
      A_SUB:   f.of = (b[63] != a[63]) && (r[63] != b[63]);
      default: f.of = 1'b0;
    endcase
    return f;
  endfunction

  function automatic logic cond_eval(input logic [3:0] fun, input cc_t cc);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (fun)
      4'h0:    return 1'b1;
      4'h1:    return lt | cc.zf;
      4'h2:    return lt;
      4'h3:    return cc.zf;
      4'h4:    return ~cc.zf;
      4'h5:    return ~lt;
      4'h6:    return ~lt & ~cc.zf;
      default: return 1'b0;
    endcase
  endfunction

  logic signed [63:0] alu_a;
  logic signed [63:0] alu_b;
  logic signed [63:0] alu_r;
  logic [3:0]         alu_fun;
  cc_t                alu_cc;
  cc_t                cc_q, cc_d;
  logic               set_cc;
  logic               cnd;
  logic [3:0]         dst_e;
  m_reg_t             m_q, m_d;

  always_comb begin
    alu_a = 64'sd0;
    case (ex.E_icode)
      I_RRMOVQ, I_OPQ:           alu_a = $signed(ex.E_valA);
      I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ:                  alu_a = $signed(ex.E_valC);
      I_CALL, I_PUSHQ:           alu_a = -STACK_STEP;
      I_RET, I_POPQ:             alu_a = STACK_STEP;
      default:                   alu_a = 64'sd0;
    endcase
  end

  always_comb begin
    alu_b = 64'sd0;
    case (ex.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ,
      I_CALL, I_RET, I_PUSHQ,
      I_POPQ:                    alu_b = $signed(ex.E_valB);
      default:                   alu_b = 64'sd0;
    endcase
  end

  always_comb begin
    alu_fun = (ex.E_icode == I_OPQ) ? ex.E_ifun : A_ADD;
    alu_r   = alu_result(alu_fun, alu_a, alu_b);
    alu_cc  = alu_flags(alu_fun, alu_a, alu_b, alu_r);
  end

  // Conditions read the held CC, so an OPq's flags reach the next instruction.
  always_comb begin
    set_cc = (ex.E_icode == I_OPQ) && (ex.m_stat == S_AOK) && (ex.W_stat == S_AOK);
    cc_d   = set_cc ? alu_cc : cc_q;
    cnd    = cond_eval(ex.E_ifun, cc_q);
    dst_e  = ((ex.E_icode == I_RRMOVQ) && !cnd) ? R_NONE : ex.E_dstE;
  end

  always_comb begin
    m_d = M_NOP;
    if (!ex.M_bubble) begin
      m_d.stat  = ex.E_stat;
      m_d.icode = ex.E_icode;
      m_d.cnd   = cnd;
      m_d.val_e = alu_r;
      m_d.val_a = ex.E_valA;
      m_d.dst_e = dst_e;
      m_d.dst_m = ex.E_dstM;
    end
  end

  // E->M register boundary and condition-code state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
      m_q  <= M_NOP;
    end else begin
      cc_q <= cc_d;
      m_q  <= m_d;
    end
  end

  assign ex.e_valE  = alu_r;
  assign ex.e_dstE  = dst_e;
  assign ex.e_Cnd   = cnd;

  assign ex.M_stat  = m_q.stat;
  assign ex.M_icode = m_q.icode;
  assign ex.M_Cnd   = m_q.cnd;
  assign ex.M_valE  = m_q.val_e;
  assign ex.M_valA  = m_q.val_a;
  assign ex.M_dstE  = m_q.dst_e;
  assign ex.M_dstM  = m_q.dst_m;

endmodule

// File: tb/tb_pipe_execute.sv
// Bench for pipe_execute: directed vectors with literal expectations plus an
// instruction-level reference model compared every cycle.
module tb_pipe_execute;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipe_execute_if bus ();

  pipe_execute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain instruction semantics
  function automatic logic [63:0] mdl_val(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] c, input logic [63:0] a,
                                          input logic [63:0] b);
    case (ic)
      4'h2:       return a;
      4'h3:       return c;
      4'h4, 4'h5: return b + c;
      4'h6: begin
        case (fn)
          4'h0:    return b + a;
          4'h1:    return b - a;
          4'h2:    return b & a;
          4'h3:    return b ^ a;
          default: return 64'd0;
        endcase
      end
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default:    return 64'd0;
    endcase
  endfunction

  // {ZF,SF,OF}; overflow means the true signed result does not fit in 64 bits
  function automatic logic [2:0] mdl_flags(input logic [3:0] fn, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [63:0]        r;
    logic signed [64:0] wide;
    logic               of;
    r  = mdl_val(4'h6, fn, 64'd0, a, b);
    of = 1'b0;
    if (fn == 4'h0) begin
      wide = $signed({b[63], b}) + $signed({a[63], a});
      of   = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
    end else if (fn == 4'h1) begin
      wide = $signed({b[63], b}) - $signed({a[63], a});
      of   = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
    end
    return {r == 64'd0, r[63], of};
  endfunction

  function automatic logic mdl_cond(input logic [3:0] fn, input logic zf,
                                    input logic sf, input logic of);
    logic less;
    less = (sf != of);
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return less || zf;
      4'h2:    return less;
      4'h3:    return zf;
      4'h4:    return !zf;
      4'h5:    return !less;
      4'h6:    return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  logic        mzf, msf, mof;
  logic [1:0]  x_stat;
  logic [3:0]  x_icode;
  logic        x_cnd;
  logic [63:0] x_valE, x_valA;
  logic [3:0]  x_dstE, x_dstM;

  always @(posedge clk or negedge rst_n) begin
    logic c;
    logic [2:0] f;
    if (!rst_n) begin
      {mzf, msf, mof} <= 3'b100;
      x_stat <= 2'b00; x_icode <= 4'h1; x_cnd <= 1'b0;
      x_valE <= 64'd0; x_valA <= 64'd0; x_dstE <= 4'hF; x_dstM <= 4'hF;
    end else begin
      c = mdl_cond(bus.E_ifun, mzf, msf, mof);
      if (bus.M_bubble) begin
        x_stat <= 2'b00; x_icode <= 4'h1; x_cnd <= 1'b0;
        x_valE <= 64'd0; x_valA <= 64'd0; x_dstE <= 4'hF; x_dstM <= 4'hF;
      end else begin
        x_stat  <= bus.E_stat;
        x_icode <= bus.E_icode;
        x_cnd   <= c;
        x_valE  <= mdl_val(bus.E_icode, bus.E_ifun, bus.E_valC, bus.E_valA, bus.E_valB);
        x_valA  <= bus.E_valA;
        x_dstE  <= (bus.E_icode == 4'h2 && !c) ? 4'hF : bus.E_dstE;
        x_dstM  <= bus.E_dstM;
      end
      if (bus.E_icode == 4'h6 && bus.m_stat == 2'b00 && bus.W_stat == 2'b00) begin
        f = mdl_flags(bus.E_ifun, bus.E_valA, bus.E_valB);
        {mzf, msf, mof} <= f;
      end
    end
  end

  always @(negedge clk) begin
    logic c;
    c = mdl_cond(bus.E_ifun, mzf, msf, mof);
    chk("cyc_e_valE", bus.e_valE,
        mdl_val(bus.E_icode, bus.E_ifun, bus.E_valC, bus.E_valA, bus.E_valB));
    chk("cyc_e_Cnd", 64'(bus.e_Cnd), 64'(c));
    chk("cyc_e_dstE", 64'(bus.e_dstE),
        64'((bus.E_icode == 4'h2 && !c) ? 4'hF : bus.E_dstE));
    chk("cyc_M_stat", 64'(bus.M_stat), 64'(x_stat));
    chk("cyc_M_icode", 64'(bus.M_icode), 64'(x_icode));
    chk("cyc_M_Cnd", 64'(bus.M_Cnd), 64'(x_cnd));
    chk("cyc_M_valE", bus.M_valE, x_valE);
    chk("cyc_M_valA", bus.M_valA, x_valA);
    chk("cyc_M_dstE", 64'(bus.M_dstE), 64'(x_dstE));
    chk("cyc_M_dstM", 64'(bus.M_dstM), 64'(x_dstM));
  end

  task automatic drive(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] de, input logic [3:0] dm);
    bus.E_stat = st; bus.E_icode = ic; bus.E_ifun = fn;
    bus.E_valC = c;  bus.E_valA = a;   bus.E_valB = b;
    bus.E_dstE = de; bus.E_dstM = dm;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.m_stat = 2'b00; bus.W_stat = 2'b00; bus.M_bubble = 1'b0;
    drive(2'b00, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    tick; tick;
    chk("rst_M_icode", 64'(bus.M_icode), 64'h1);
    chk("rst_M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("rst_M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("rst_M_stat", 64'(bus.M_stat), 64'h0);
    rst_n = 1'b1;

    // subq 5 from 3
    drive(2'b00, 4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h2, 4'hF);
    #1 chk("sub_e_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick;
    chk("sub_M_valE", bus.M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_M_icode", 64'(bus.M_icode), 64'h6);
    drive(2'b00, 4'h7, 4'h2, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("jl_after_sub", 64'(bus.e_Cnd), 64'h1);
    bus.E_ifun = 4'h3;
    #1 chk("je_after_sub", 64'(bus.e_Cnd), 64'h0);
    bus.E_ifun = 4'h6;
    #1 chk("jg_after_sub", 64'(bus.e_Cnd), 64'h0);
    tick;

    // signed overflow on addq
    drive(2'b00, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 4'hF);
    #1 chk("ovf_e_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick;
    drive(2'b00, 4'h2, 4'h2, 64'd0, 64'h55, 64'd0, 4'h3, 4'hF);
    #1 chk("cmovl_e_dstE", 64'(bus.e_dstE), 64'hF);
    chk("cmovl_e_Cnd", 64'(bus.e_Cnd), 64'h0);
    tick;
    chk("cmovl_M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("cmovl_M_valE", bus.M_valE, 64'h55);
    drive(2'b00, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("jge_after_ovf", 64'(bus.e_Cnd), 64'h1);

    // stack and address arithmetic
    drive(2'b00, 4'hA, 4'h0, 64'd0, 64'h9, 64'h100, 4'h4, 4'hF);
    #1 chk("pushq_e_valE", bus.e_valE, 64'hF8);
    drive(2'b00, 4'hB, 4'h0, 64'd0, 64'h0, 64'h100, 4'h4, 4'h1);
    #1 chk("popq_e_valE", bus.e_valE, 64'h108);
    drive(2'b00, 4'h5, 4'h0, 64'h10, 64'h0, 64'h20, 4'hF, 4'h2);
    #1 chk("mrmovq_e_valE", bus.e_valE, 64'h30);
    tick;

    // CC suppression by downstream status
    drive(2'b00, 4'h6, 4'h3, 64'd0, 64'h1234, 64'h1234, 4'h1, 4'hF);
    bus.m_stat = 2'b10;
    tick;
    bus.m_stat = 2'b00;
    drive(2'b00, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("je_mstat_held", 64'(bus.e_Cnd), 64'h0);
    drive(2'b00, 4'h6, 4'h3, 64'd0, 64'h1234, 64'h1234, 4'h1, 4'hF);
    tick;
    drive(2'b00, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("je_xor_zero", 64'(bus.e_Cnd), 64'h1);
    drive(2'b00, 4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h1, 4'hF);
    bus.W_stat = 2'b01;
    tick;
    bus.W_stat = 2'b00;
    drive(2'b00, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("je_wstat_held", 64'(bus.e_Cnd), 64'h1);

    // bubble
    drive(2'b00, 4'h3, 4'h0, 64'd7, 64'd0, 64'd0, 4'h5, 4'hF);
    bus.M_bubble = 1'b1;
    tick;
    chk("bub_M_icode", 64'(bus.M_icode), 64'h1);
    chk("bub_M_dstE", 64'(bus.M_dstE), 64'hF);
    bus.M_bubble = 1'b0;
    tick;
    chk("irmov_M_valE", bus.M_valE, 64'h7);
    chk("irmov_M_dstE", 64'(bus.M_dstE), 64'h5);
    drive(2'b00, 4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h1, 4'hF);
    bus.M_bubble = 1'b1;
    tick;
    bus.M_bubble = 1'b0;
    chk("bubcc_M_icode", 64'(bus.M_icode), 64'h1);
    drive(2'b00, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("jl_after_bub_cc", 64'(bus.e_Cnd), 64'h1);

    // status propagation and out-of-range functions
    drive(2'b10, 4'h6, 4'h0, 64'd0, 64'd1, 64'd2, 4'h3, 4'hF);
    tick;
    chk("exc_M_stat", 64'(bus.M_stat), 64'h2);
    chk("exc_M_valE", bus.M_valE, 64'h3);
    drive(2'b00, 4'h6, 4'h4, 64'd0, 64'd5, 64'd3, 4'h3, 4'hF);
    #1 chk("opq_bad_fun", bus.e_valE, 64'h0);
    drive(2'b00, 4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("jxx_bad_fun", 64'(bus.e_Cnd), 64'h0);
    tick;

    // asynchronous reset mid-cycle
    drive(2'b00, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    #1 chk("je_before_rst", 64'(bus.e_Cnd), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("arst_e_Cnd", 64'(bus.e_Cnd), 64'h1);
    chk("arst_M_icode", 64'(bus.M_icode), 64'h1);
    chk("arst_M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("arst_M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("arst_M_stat", 64'(bus.M_stat), 64'h0);
    tick;
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      logic [3:0] ic;
      ic = 4'($urandom_range(0, 11));
      drive(2'($urandom_range(0, 3)), ic, 4'($urandom_range(0, 7)),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      bus.m_stat   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.W_stat   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.M_bubble = ($urandom_range(0, 4) == 0);
      tick;
    end
    bus.M_bubble = 1'b0;
    bus.m_stat = 2'b00;
    bus.W_stat = 2'b00;
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
